// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory-access stage.
//  - hs_state_t   : data-memory handshake FSM states
//  - memwb_t      : MEM/WB boundary payload
//  - MEMWB_BUBBLE : payload loaded when no instruction retires this cycle
package mem_stage_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned REG_W = 5;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } hs_state_t;

  typedef struct packed {
    logic             reg_write;
    logic             mem_to_reg;
    logic [XLEN-1:0]  read_data;
    logic [XLEN-1:0]  alu_out;
    logic [REG_W-1:0] write_reg;
  } memwb_t;

  // A bubble writes nothing back; the data fields are zeroed for clarity in traces.
  localparam memwb_t MEMWB_BUBBLE = '0;

endpackage

// File: rtl/mem_stage_dmem_handshake.sv
// Data-memory req/ack handshake with timeout.
//  CLK, RSTn            : clock, async active-low reset
//  access, is_write     : instruction needs memory / is a store
//  addr, wdata          : ALU address and store data from EX/MEM
//  ack                  : one-cycle completion strobe from memory
//  dmem_req/we/addr/wdata : registered memory bus
//  bus_err              : sticky timeout/trap flag
//  stall_c              : hold the front of the pipe this cycle
//  pass_c               : non-memory instruction retires this cycle
//  done_c               : memory instruction completes this cycle
// Optional macro MEM_STAGE_MISALIGN_TRAP_EN: trap misaligned accesses instead of
// silently clearing the low address bits.
module mem_stage_dmem_handshake
  import mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_W          = 5
) (
  input  logic            CLK,
  input  logic            RSTn,
  input  logic            access,
  input  logic            is_write,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  input  logic            ack,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic            bus_err,
  output logic            stall_c,
  output logic            pass_c,
  output logic            done_c
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  hs_state_t        state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             req_d, we_d, err_d;
  logic [XLEN-1:0]  addr_d, wdata_d;
  logic             misalign_c;

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
  assign misalign_c = |addr[1:0];
`else
  logic unused_addr_lsb;
  assign misalign_c      = 1'b0;
  assign unused_addr_lsb = ^addr[1:0];
`endif

  // State and bus registers
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      bus_err    <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      dmem_req   <= req_d;
      dmem_we    <= we_d;
      dmem_addr  <= addr_d;
      dmem_wdata <= wdata_d;
      bus_err    <= err_d;
    end
  end

  // Next state, bus updates and stage-control strobes
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    req_d   = dmem_req;
    we_d    = dmem_we;
    addr_d  = dmem_addr;
    wdata_d = dmem_wdata;
    err_d   = bus_err;
    stall_c = 1'b0;
    pass_c  = 1'b0;
    done_c  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!access) begin
          pass_c = 1'b1;
        end else if (misalign_c) begin
          err_d = 1'b1;
        end else begin
          stall_c = 1'b1;
          req_d   = 1'b1;
          we_d    = is_write;
          addr_d  = {addr[XLEN-1:2], 2'b00};
          wdata_d = wdata;
          cnt_d   = '0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Ack takes priority over a timeout in the same cycle.
        if (ack) begin
          done_c  = 1'b1;
          req_d   = 1'b0;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (cnt == CNT_LAST) begin
          err_d   = 1'b1;
          req_d   = 1'b0;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          stall_c = 1'b1;
          cnt_d   = cnt + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: drives the data-memory bus, stalls upstream while an
// access is outstanding, registers the MEM/WB boundary and resolves branches.
//  CLK, RSTn          : clock, async active-low reset
//  in_*               : EX/MEM register contents
//  PCSrc, PCBranch    : branch decision and target to fetch (combinational)
//  Stall              : hold PC, IF/ID, ID/EX, EX/MEM this cycle (combinational)
//  dmem_*             : data-memory req/ack bus
//  RegWrite..WriteReg : MEM/WB register
//  BusErr             : sticky; timeout or misalign trap, cleared by reset
// Optional macro MEM_STAGE_MISALIGN_TRAP_EN enables the misaligned-access trap.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_W          = 5
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             in_RegWrite,
  input  logic             in_MemtoReg,
  input  logic             in_MemWrite,
  input  logic             in_Branch,
  input  logic             in_zero,
  input  logic [XLEN-1:0]  in_ALUOut,
  input  logic [XLEN-1:0]  in_WriteData,
  input  logic [REG_W-1:0] in_WriteReg,
  input  logic [XLEN-1:0]  in_PCBranch,
  output logic             PCSrc,
  output logic [XLEN-1:0]  PCBranch,
  output logic             Stall,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [XLEN-1:0]  dmem_addr,
  output logic [XLEN-1:0]  dmem_wdata,
  input  logic [XLEN-1:0]  dmem_rdata,
  input  logic             dmem_ack,
  output logic             RegWrite,
  output logic             MemtoReg,
  output logic [XLEN-1:0]  ReadData,
  output logic [XLEN-1:0]  ALUOut,
  output logic [REG_W-1:0] WriteReg,
  output logic             BusErr
);

  logic   access_c, pass_c, done_c;
  memwb_t memwb_d, memwb_q;

  assign access_c = in_MemtoReg | in_MemWrite;

  // Branch resolution back to fetch
  assign PCSrc    = in_Branch & in_zero;
  assign PCBranch = in_PCBranch;

  mem_stage_dmem_handshake #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_hs (
    .CLK        (CLK),
    .RSTn       (RSTn),
    .access     (access_c),
    .is_write   (in_MemWrite),
    .addr       (in_ALUOut),
    .wdata      (in_WriteData),
    .ack        (dmem_ack),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .bus_err    (BusErr),
    .stall_c    (Stall),
    .pass_c     (pass_c),
    .done_c     (done_c)
  );

  // MEM/WB next value: retire the instruction or insert a bubble
  always_comb begin
    memwb_d = MEMWB_BUBBLE;
    if (pass_c) begin
      memwb_d = '{reg_write: in_RegWrite, mem_to_reg: in_MemtoReg, read_data: '0,
                  alu_out: in_ALUOut, write_reg: in_WriteReg};
    end else if (done_c) begin
      memwb_d = '{reg_write: in_RegWrite, mem_to_reg: in_MemtoReg, read_data: dmem_rdata,
                  alu_out: in_ALUOut, write_reg: in_WriteReg};
    end
  end

  // MEM/WB register
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) memwb_q <= MEMWB_BUBBLE;
    else       memwb_q <= memwb_d;
  end

  assign RegWrite = memwb_q.reg_write;
  assign MemtoReg = memwb_q.mem_to_reg;
  assign ReadData = memwb_q.read_data;
  assign ALUOut   = memwb_q.alu_out;
  assign WriteReg = memwb_q.write_reg;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a scoreboard of expected MEM/WB results.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        CLK, RSTn;
  logic        in_RegWrite, in_MemtoReg, in_MemWrite, in_Branch, in_zero;
  logic [31:0] in_ALUOut, in_WriteData, in_PCBranch;
  logic [4:0]  in_WriteReg;
  logic        PCSrc, Stall, dmem_req, dmem_we, dmem_ack;
  logic [31:0] PCBranch, dmem_addr, dmem_wdata, dmem_rdata;
  logic        RegWrite, MemtoReg, BusErr;
  logic [31:0] ReadData, ALUOut;
  logic [4:0]  WriteReg;

  int checks = 0;
  int failures = 0;
  memwb_t sb_q[$];

  // results of the last run_access call
  int          ra_stalls, ra_waits;
  logic        ra_we, ra_stable, ra_bubble;
  logic [31:0] ra_addr, ra_wdata;

  mem_stage #(.TIMEOUT_CYCLES(4), .CNT_W(5)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .in_RegWrite(in_RegWrite), .in_MemtoReg(in_MemtoReg), .in_MemWrite(in_MemWrite),
    .in_Branch(in_Branch), .in_zero(in_zero), .in_ALUOut(in_ALUOut),
    .in_WriteData(in_WriteData), .in_WriteReg(in_WriteReg), .in_PCBranch(in_PCBranch),
    .PCSrc(PCSrc), .PCBranch(PCBranch), .Stall(Stall),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .RegWrite(RegWrite), .MemtoReg(MemtoReg), .ReadData(ReadData), .ALUOut(ALUOut),
    .WriteReg(WriteReg), .BusErr(BusErr)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pop the oldest expected MEM/WB value and compare it with the register.
  task automatic sb_check(input string tag);
    memwb_t obs, exp;
    obs = '{RegWrite, MemtoReg, ReadData, ALUOut, WriteReg};
    if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s observed=%0h expected=<empty scoreboard>", tag, obs);
    end else begin
      exp = sb_q.pop_front();
      chk(tag, 96'(obs), 96'(exp));
    end
  endtask

  task automatic set_in(input logic rw, input logic m2r, input logic mw,
                        input logic [31:0] a, input logic [31:0] wd, input logic [4:0] wr);
    in_RegWrite = rw; in_MemtoReg = m2r; in_MemWrite = mw;
    in_ALUOut = a; in_WriteData = wd; in_WriteReg = wr;
  endtask

  // Memory model: acks on the WAIT cycle with index ack_after (-1 = never).
  // Entered and left at posedge+1; counts stalled cycles and WAIT cycles.
  task automatic run_access(input int ack_after, input logic [31:0] rdata);
    ra_stalls = 0; ra_waits = 0; ra_stable = 1'b1; ra_bubble = 1'b1;
    ra_we = 1'b0; ra_addr = '0; ra_wdata = '0;
    for (int c = 0; c < 40; c++) begin
      if (dmem_req) begin
        if (ra_waits == 0) begin
          ra_we = dmem_we; ra_addr = dmem_addr; ra_wdata = dmem_wdata;
        end else if (dmem_we !== ra_we || dmem_addr !== ra_addr || dmem_wdata !== ra_wdata) begin
          ra_stable = 1'b0;
        end
        if (RegWrite !== 1'b0 || MemtoReg !== 1'b0) ra_bubble = 1'b0;
        dmem_ack   = (ack_after >= 0 && ra_waits == ack_after);
        dmem_rdata = dmem_ack ? rdata : 32'h0;
        ra_waits++;
      end
      #1;
      if (Stall) ra_stalls++;
      @(posedge CLK); #1;
      dmem_ack = 1'b0;
      if (ra_waits > 0 && !dmem_req) break;
    end
  endtask

  initial begin
    RSTn = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    in_Branch = 1'b0; in_zero = 1'b0; in_PCBranch = 32'h0;
    dmem_ack = 1'b0; dmem_rdata = 32'h0;
    #2;
    chk("reset_req", 96'(dmem_req), 96'(0));
    chk("reset_bus", 96'({dmem_we, dmem_addr, dmem_wdata}), 96'(0));
    chk("reset_memwb", 96'({RegWrite, MemtoReg, ReadData, ALUOut, WriteReg}), 96'(0));
    chk("reset_buserr", 96'(BusErr), 96'(0));
    @(negedge CLK); RSTn = 1'b1;
    @(posedge CLK); #1;

    // ALU op retires with latency 1
    set_in(1'b1, 1'b0, 1'b0, 32'h1234, 32'hAAAA, 5'd5);
    #1 chk("alu_stall", 96'(Stall), 96'(0));
    sb_q.push_back('{1'b1, 1'b0, 32'h0, 32'h1234, 5'd5});
    @(posedge CLK); #1;
    sb_check("alu_op");
    chk("alu_noreq", 96'(dmem_req), 96'(0));

    // Branch resolution is combinational
    set_in(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    in_Branch = 1'b1; in_zero = 1'b1; in_PCBranch = 32'h40;
    #1 chk("br_taken", 96'(PCSrc), 96'(1));
    chk("br_target", 96'(PCBranch), 96'(32'h40));
    in_zero = 1'b0;
    #1 chk("br_not_taken", 96'(PCSrc), 96'(0));
    in_Branch = 1'b0;
    @(posedge CLK); #1;

    // ack in IDLE is ignored; ReadData stays 0 for non-memory ops
    set_in(1'b1, 1'b0, 1'b0, 32'h77, 32'h0, 5'd2);
    dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    sb_q.push_back('{1'b1, 1'b0, 32'h0, 32'h77, 5'd2});
    @(posedge CLK); #1;
    dmem_ack = 1'b0; dmem_rdata = 32'h0;
    sb_check("idle_ack_ignored");
    chk("idle_ack_noreq", 96'(dmem_req), 96'(0));

    // Load, ack on 4th WAIT cycle
    set_in(1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 5'd7);
    sb_q.push_back('{1'b1, 1'b1, 32'hDEAD_BEEF, 32'h100, 5'd7});
    run_access(3, 32'hDEAD_BEEF);
    sb_check("load");
    chk("load_stalls", 96'(ra_stalls), 96'(4));
    chk("load_bus", 96'({ra_we, ra_addr}), 96'({1'b0, 32'h100}));
    chk("load_wait_bubble", 96'(ra_bubble), 96'(1));
    chk("load_req_dropped", 96'(dmem_req), 96'(0));

    // Minimum-latency load
    set_in(1'b1, 1'b1, 1'b0, 32'h104, 32'h0, 5'd3);
    sb_q.push_back('{1'b1, 1'b1, 32'h0BAD_F00D, 32'h104, 5'd3});
    run_access(0, 32'h0BAD_F00D);
    sb_check("load_min");
    chk("load_min_stalls", 96'(ra_stalls), 96'(1));

    // Store holds the bus until ack and writes nothing back
    set_in(1'b0, 1'b0, 1'b1, 32'h200, 32'h55, 5'd9);
    sb_q.push_back('{1'b0, 1'b0, 32'h0, 32'h200, 5'd9});
    run_access(1, 32'h0);
    sb_check("store");
    chk("store_bus", 96'({ra_we, ra_addr, ra_wdata}), 96'({1'b1, 32'h200, 32'h55}));
    chk("store_bus_stable", 96'(ra_stable), 96'(1));
    chk("store_waits", 96'(ra_waits), 96'(2));

    // Ack on the timeout cycle wins
    set_in(1'b1, 1'b1, 1'b0, 32'h300, 32'h0, 5'd8);
    sb_q.push_back('{1'b1, 1'b1, 32'h1234_5678, 32'h300, 5'd8});
    run_access(3, 32'h1234_5678);
    sb_check("ack_at_timeout");
    chk("ack_at_timeout_buserr", 96'(BusErr), 96'(0));

    // Timeout: 4 WAIT cycles then abandon
    set_in(1'b1, 1'b1, 1'b0, 32'h400, 32'h0, 5'd4);
    sb_q.push_back(MEMWB_BUBBLE);
    run_access(-1, 32'h0);
    sb_check("timeout_bubble");
    chk("timeout_waits", 96'(ra_waits), 96'(4));
    chk("timeout_stalls", 96'(ra_stalls), 96'(4));
    chk("timeout_buserr", 96'(BusErr), 96'(1));
    set_in(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    @(posedge CLK); #1;
    chk("buserr_sticky", 96'(BusErr), 96'(1));

    // Reset in the middle of WAIT
    set_in(1'b1, 1'b1, 1'b0, 32'h500, 32'h0, 5'd1);
    @(posedge CLK); #1;
    chk("midwait_req", 96'(dmem_req), 96'(1));
    @(posedge CLK); #2;
    RSTn = 1'b0;
    #1;
    chk("rst_req", 96'(dmem_req), 96'(0));
    chk("rst_bus", 96'({dmem_we, dmem_addr, dmem_wdata}), 96'(0));
    chk("rst_buserr", 96'(BusErr), 96'(0));
    chk("rst_memwb", 96'({RegWrite, MemtoReg, ReadData, ALUOut, WriteReg}), 96'(0));
    set_in(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    @(negedge CLK); RSTn = 1'b1;
    @(posedge CLK); #1;

    // Misaligned load
    set_in(1'b1, 1'b1, 1'b0, 32'h102, 32'h0, 5'd6);
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    #1 chk("trap_stall", 96'(Stall), 96'(0));
    sb_q.push_back(MEMWB_BUBBLE);
    @(posedge CLK); #1;
    set_in(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    sb_check("trap_bubble");
    chk("trap_noreq", 96'(dmem_req), 96'(0));
    chk("trap_buserr", 96'(BusErr), 96'(1));
`else
    sb_q.push_back('{1'b1, 1'b1, 32'hCAFE_F00D, 32'h102, 5'd6});
    run_access(0, 32'hCAFE_F00D);
    set_in(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    sb_check("misalign_load");
    chk("misalign_addr", 96'(ra_addr), 96'(32'h100));
    chk("misalign_buserr", 96'(BusErr), 96'(0));
`endif

    chk("scoreboard_drained", 96'(sb_q.size()), 96'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
